// File: rtl/sequential_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock.
// Optional two's-complement operation is enabled with the macro DIVIDER_SIGNED_EN;
// without it operands are unsigned and the FIX state is not built.
module sequential_restoring_divider #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   input  logic                  data_valid_i,
   output logic [DATA_WIDTH-1:0] quotient_o,
   output logic [DATA_WIDTH-1:0] remainder_o,
   output logic                  divide_by_zero_o,
   output logic                  data_valid_o,
   output logic                  idle_o,
   output logic [1:0]            state_o
);

   // Handshake: a request (data_valid_i=1) is accepted on a rising edge only while
   // idle_o=1; requests while idle_o=0 are dropped, not queued. data_valid_o is a
   // single-cycle pulse marking the cycle in which quotient_o/remainder_o were updated.

   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
`ifdef DIVIDER_SIGNED_EN
      S_FIX    = 2'd2,
`endif
      S_DONE   = 2'd3
   } state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] a_reg;   // dividend bits shift out, quotient bits shift in
   logic [DATA_WIDTH-1:0] d_reg;   // divisor (magnitude)
   logic [DATA_WIDTH-1:0] p_reg;   // partial remainder, always < divisor so W bits suffice

   logic [DATA_WIDTH:0]   shifted;
   logic                  trial_neg;
   logic [DATA_WIDTH-1:0] p_next;
   logic [DATA_WIDTH-1:0] q_next;
   logic [DATA_WIDTH-1:0] dividend_mag;
   logic [DATA_WIDTH-1:0] divisor_mag;
   logic                  accept;

`ifdef DIVIDER_SIGNED_EN
   logic q_neg;
   logic r_neg;
`endif

   assign state_o = state;
   assign accept  = data_valid_i && ((state == S_IDLE) || (state == S_DONE));

   // One restoring step: shift in the next dividend bit and try subtracting the divisor.
   always_comb begin
      shifted   = {p_reg, a_reg[DATA_WIDTH-1]};
      trial_neg = shifted < {1'b0, d_reg};
      // Result of a successful trial is < divisor, so the low W bits are exact.
      p_next    = trial_neg ? shifted[DATA_WIDTH-1:0] : (shifted[DATA_WIDTH-1:0] - d_reg);
      q_next    = {a_reg[DATA_WIDTH-2:0], ~trial_neg};
   end

   // Operand magnitudes fed to the unsigned core.
   always_comb begin
`ifdef DIVIDER_SIGNED_EN
      dividend_mag = dividend_i[DATA_WIDTH-1] ? (~dividend_i + 1'b1) : dividend_i;
      divisor_mag  = divisor_i[DATA_WIDTH-1]  ? (~divisor_i + 1'b1)  : divisor_i;
`else
      dividend_mag = dividend_i;
      divisor_mag  = divisor_i;
`endif
   end

   // Control FSM plus datapath and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state            <= S_IDLE;
         cnt              <= '0;
         a_reg            <= '0;
         d_reg            <= '0;
         p_reg            <= '0;
         quotient_o       <= '0;
         remainder_o      <= '0;
         divide_by_zero_o <= 1'b0;
         data_valid_o     <= 1'b0;
         idle_o           <= 1'b1;
`ifdef DIVIDER_SIGNED_EN
         q_neg            <= 1'b0;
         r_neg            <= 1'b0;
`endif
      end else begin
         data_valid_o <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (divisor_i == '0) begin
                     // Divide-by-zero completes immediately with all-ones quotient.
                     state            <= S_DONE;
                     quotient_o       <= '1;
                     remainder_o      <= dividend_i;
                     divide_by_zero_o <= 1'b1;
                     data_valid_o     <= 1'b1;
                     idle_o           <= 1'b1;
                  end else begin
                     state            <= S_DIVIDE;
                     a_reg            <= dividend_mag;
                     d_reg            <= divisor_mag;
                     p_reg            <= '0;
                     cnt              <= CW'(DATA_WIDTH - 1);
                     divide_by_zero_o <= 1'b0;
                     idle_o           <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                     q_neg            <= dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1];
                     r_neg            <= dividend_i[DATA_WIDTH-1];
`endif
                  end
               end else begin
                  state            <= S_IDLE;
                  divide_by_zero_o <= 1'b0;
                  idle_o           <= 1'b1;
               end
            end
            S_DIVIDE: begin
               a_reg <= q_next;
               p_reg <= p_next;
               if (cnt == '0) begin
`ifdef DIVIDER_SIGNED_EN
                  state        <= S_FIX;
`else
                  state        <= S_DONE;
                  quotient_o   <= q_next;
                  remainder_o  <= p_next;
                  data_valid_o <= 1'b1;
                  idle_o       <= 1'b1;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`ifdef DIVIDER_SIGNED_EN
            S_FIX: begin
               // Truncating division: quotient sign from operand signs, remainder follows dividend.
               state        <= S_DONE;
               quotient_o   <= q_neg ? (~a_reg + 1'b1) : a_reg;
               remainder_o  <= r_neg ? (~p_reg + 1'b1) : p_reg;
               data_valid_o <= 1'b1;
               idle_o       <= 1'b1;
            end
`endif
            default: begin
               state  <= S_IDLE;
               idle_o <= 1'b1;
            end
         endcase
      end
   end

endmodule
